// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and width helpers for the systolic tile sequencer
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        STREAM  = 3'd2,
        DRAIN   = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int ROWS_DEF    = 4;
    localparam int MAC_LAT_DEF = 2;
    localparam int DRAIN_CYC   = ROWS_DEF + MAC_LAT_DEF - 1;

    // Width that can hold every value 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int drain_cycles(input int rows, input int mac_lat);
        return rows + mac_lat - 1;
    endfunction

endpackage

// File: rtl/systolic_tile_ctrl_skew.sv
// rtl/systolic_tile_ctrl_skew.sv - 1-bit-per-row skew shift register; row r sees the input delayed r cycles
module skew_shift #(
    parameter int ROWS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            valid_i,
    output logic [ROWS-1:0] skew_o
);

    generate
        if (ROWS == 1) begin : g_single
            assign skew_o = valid_i;
        end else begin : g_chain
            // Row 0 is the live input, so only ROWS-1 stages need storage.
            logic [ROWS-2:0] sr_q;

            always_ff @(posedge clk) begin
                if (rst || clr_i) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= skew_o[ROWS-2:0];
                end
            end

            assign skew_o = {sr_q, valid_i};
        end
    endgenerate

endmodule

// File: rtl/systolic_tile_ctrl.sv
// rtl/systolic_tile_ctrl.sv - LOAD/STREAM/DRAIN/CAPTURE sequencer for a weight-stationary tile; SYSTOLIC_CTRL_PERF_EN adds perf counters
module systolic_tile_ctrl
    import systolic_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int K_MAX   = 256,
    parameter int MAC_LAT = 2,
    parameter int KW      = cnt_width(K_MAX),
    parameter int AW      = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int YW      = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            reuse_w,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            c_enable,
    output logic [AW-1:0]   w_rd_addr,
    output logic [KW-1:0]   k_idx,
    output logic [ROWS-1:0] skew_valid,
    output logic            y_valid,
    output logic [YW-1:0]   y_col,
    output logic [31:0]     busy_cycles,
    output logic [15:0]     tile_count
);

    localparam int DCYC = drain_cycles(ROWS, MAC_LAT);
    localparam int CW   = cnt_width(ROWS + COLS + DCYC);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] k_idx_q, k_idx_d;
    logic [KW-1:0] k_len_q, k_len_d;
    logic          w_loaded_q, w_loaded_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_idx_d    = k_idx_q;
        k_len_d    = k_len_q;
        w_loaded_d = w_loaded_q;

        case (state_q)
            IDLE: begin
                if (start && (k_len != '0) && (k_len <= KW'(K_MAX))) begin
                    k_len_d = k_len;
                    if (reuse_w && w_loaded_q) begin
                        state_d = STREAM;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = CW'(ROWS - 1);
                    end
                end
            end
            LOAD: begin
                if (cnt_q == '0) begin
                    state_d    = STREAM;
                    w_loaded_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STREAM: begin
                // k_idx stops on the last beat and holds through DRAIN.
                if (k_idx_q == k_len_q - KW'(1)) begin
                    state_d = DRAIN;
                    cnt_d   = CW'(DCYC - 1);
                end else begin
                    k_idx_d = k_idx_q + KW'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            CAPTURE: begin
                if (cnt_q == CW'(COLS - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            if (state_q == LOAD) begin
                w_loaded_d = 1'b0;
            end
        end

        if (state_d == IDLE) begin
            cnt_d   = '0;
            k_idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            k_idx_q    <= '0;
            k_len_q    <= '0;
            w_loaded_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_idx_q    <= k_idx_d;
            k_len_q    <= k_len_d;
            w_loaded_q <= w_loaded_d;
        end
    end

    skew_shift #(.ROWS(ROWS)) u_skew (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (state_d == IDLE),
        .valid_i (state_q == STREAM),
        .skew_o  (skew_valid)
    );

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign c_enable  = (state_q == LOAD);
    assign y_valid   = (state_q == CAPTURE);
    assign w_rd_addr = (state_q == LOAD)    ? cnt_q[AW-1:0] : '0;
    assign y_col     = (state_q == CAPTURE) ? cnt_q[YW-1:0] : '0;
    assign k_idx     = k_idx_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] busy_cycles_q;
    logic [15:0] tile_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cycles_q <= '0;
            tile_count_q  <= '0;
        end else begin
            if (busy && (busy_cycles_q != '1)) begin
                busy_cycles_q <= busy_cycles_q + 32'd1;
            end
            if (done && (tile_count_q != '1)) begin
                tile_count_q <= tile_count_q + 16'd1;
            end
        end
    end

    assign busy_cycles = busy_cycles_q;
    assign tile_count  = tile_count_q;
`else
    assign busy_cycles = '0;
    assign tile_count  = '0;
`endif

endmodule
